// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes; 33 cycles from start to done.
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // Handshake: start is sampled only while busy is low. done pulses for one
   // cycle with the new hi/lo, and a start in that same cycle is accepted.
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             is_div;
   logic             neg_a;
   logic             neg_b;
   logic             div_zero;
   logic [WIDTH-1:0] opd;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_trial;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      a_mag     = (!op[0] && a[WIDTH-1]) ? -a : a;
      b_mag     = (!op[0] && b[WIDTH-1]) ? -b : b;
      add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
      rem_shift = {acc_hi, acc_lo[WIDTH-1]};
      rem_trial = rem_shift - {1'b0, opd};
      prod_fix  = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      quo_fix   = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
      rem_fix   = neg_a ? -acc_hi : acc_hi;
   end

   // Multiply: acc_hi is the running upper half, acc_lo shifts the multiplier out.
   // Divide:   acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         div_zero <= 1'b0;
         opd      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start) begin
                  is_div   <= op[1];
                  neg_a    <= !op[0] && a[WIDTH-1];
                  neg_b    <= !op[0] && b[WIDTH-1];
                  div_zero <= op[1] && (b == '0);
                  opd      <= op[1] ? b_mag : a_mag;
                  acc_lo   <= op[1] ? a_mag : b_mag;
                  acc_hi   <= '0;
                  cnt      <= '0;
                  state    <= RUN;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               if (is_div) begin
                  if (!rem_trial[WIDTH]) begin
                     acc_hi <= rem_trial[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_hi <= rem_shift[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  {acc_hi, acc_lo} <= {add_sum, acc_lo[WIDTH-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) state <= FIN;
            end
            FIN: begin
               // Divide by zero leaves |a| in the remainder, so the sign
               // fix-up hands back the original a in hi.
               if (is_div) begin
                  lo <= div_zero ? {WIDTH{1'b1}} : quo_fix;
                  hi <= rem_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
               done  <= 1'b1;
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized bench for mul_div_unit, checked against a plain
// 64-bit arithmetic reference model of the MIPS MULT/DIV rules.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   always #5 clk = ~clk;

   mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl);
      longint      sx;
      longint      sy;
      longint      res;
      logic [63:0] up;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      rh = '0;
      rl = '0;
      case (o)
         2'b00: begin
            res = sx * sy;
            up  = 64'(res);
            rh  = up[63:32];
            rl  = up[31:0];
         end
         2'b01: begin
            up = {32'b0, x} * {32'b0, y};
            rh = up[63:32];
            rl = up[31:0];
         end
         2'b10: begin
            if (y == 0) begin
               rl = 32'hFFFF_FFFF;
               rh = x;
            end else begin
               res = sx / sy;
               up  = 64'(res);
               rl  = up[31:0];
               res = sx % sy;
               up  = 64'(res);
               rh  = up[31:0];
            end
         end
         default: begin
            if (y == 0) begin
               rl = 32'hFFFF_FFFF;
               rh = x;
            end else begin
               rl = x / y;
               rh = x % y;
            end
         end
      endcase
   endfunction

   // Issues one op starting in the current cycle and waits for its done pulse.
   // On return the bench sits in the done cycle, so the next call is back-to-back.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit disturb, input string tag);
      int          n;
      logic [31:0] eh;
      logic [31:0] el;
      model(o, x, y, eh, el);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      tick;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      a     = $urandom;
      b     = $urandom;
      op    = 2'($urandom_range(0, 3));
      check({tag, " busy_after_start"}, 32'(busy), 32'd1);
      check({tag, " done_low_after_start"}, 32'(done), 32'd0);
      n = 0;
      while (n < 40 && !done) begin
         if (disturb && n == 5) begin
            start = 1'b1;
            hi_we = 1'b1;
            wdata = 32'h0000_DEAD;
         end
         tick;
         n++;
         start = 1'b0;
         hi_we = 1'b0;
         if (n == 16) begin
            check({tag, " hi_hold_mid_run"}, hi, exp_hi);
            check({tag, " lo_hold_mid_run"}, lo, exp_lo);
         end
      end
      check({tag, " latency"}, 32'(n), 32'd33);
      check({tag, " busy_in_done"}, 32'(busy), 32'd0);
      check({tag, " hi"}, hi, eh);
      check({tag, " lo"}, lo, el);
      exp_hi = eh;
      exp_lo = el;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n_done;
      logic [1:0]  r_op;
      logic [31:0] r_x;
      logic [31:0] r_y;
      logic [31:0] corner [4];
      corner[0] = 32'h0000_0000;
      corner[1] = 32'hFFFF_FFFF;
      corner[2] = 32'h8000_0000;
      corner[3] = 32'h7FFF_FFFF;

      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      wdata = '0;
      tick;
      tick;
      rst = 1'b0;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
      check("multu_max literal hi", hi, 32'hFFFF_FFFE);
      check("multu_max literal lo", lo, 32'h0000_0001);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg3x7");
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minxmin");
      check("mult_minxmin literal hi", hi, 32'h4000_0000);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7by2");
      check("div_neg7by2 literal lo", lo, 32'hFFFF_FFFD);
      run_op(2'b11, 32'd7, 32'd2, 1'b0, "divu_7by2_b2b");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
      check("div_overflow literal lo", lo, 32'h8000_0000);
      run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, "divu_by_zero");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, "div_neg_by_zero");
      check("div_neg_by_zero literal hi", hi, 32'hFFFF_FFF9);
      run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "multu_disturbed");

      tick;
      check("done_one_cycle", 32'(done), 32'd0);
      lo_we = 1'b1;
      wdata = 32'h0000_BEEF;
      tick;
      lo_we = 1'b0;
      check("mtlo lo", lo, 32'h0000_BEEF);
      check("mtlo hi_unchanged", hi, exp_hi);
      exp_lo = 32'h0000_BEEF;

      hi_we  = 1'b1;
      wdata  = 32'hCAFE_0001;
      exp_hi = 32'hCAFE_0001;
      run_op(2'b00, 32'd100, 32'hFFFF_FFFF, 1'b0, "mthi_with_start");

      op    = 2'b11;
      a     = 32'd1000;
      b     = 32'd3;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (9) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset done", 32'(done), 32'd0);
      check("midreset hi", hi, 32'd0);
      check("midreset lo", lo, 32'd0);
      exp_hi = '0;
      exp_lo = '0;
      n_done = 0;
      repeat (40) begin
         tick;
         if (done) n_done++;
      end
      check("midreset no_done", 32'(n_done), 32'd0);
      run_op(2'b01, 32'd5, 32'd6, 1'b0, "multu_after_reset");

      for (int i = 0; i < 40; i++) begin
         r_op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       r_x = corner[$urandom_range(0, 3)];
            1:       r_x = 32'($urandom_range(0, 50));
            default: r_x = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0:       r_y = corner[$urandom_range(0, 3)];
            1:       r_y = 32'($urandom_range(0, 9));
            2:       r_y = -32'($urandom_range(1, 9));
            default: r_y = $urandom;
         endcase
         run_op(r_op, r_x, r_y, ($urandom_range(0, 3) == 0), $sformatf("rand%0d_op%0d", i, r_op));
      end

      tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
